fifo_wr_arb: RTL and testbench
==============================

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 The block SHALL have parameter DW, default 32, meaning data width of each requester and of the FIFO write port.
REQ-002 The block SHALL have parameter BURST_MAX, default 8, range 1..32, meaning maximum words accepted per grant.
REQ-003 Port clk, input, 1: single clock, all state on rising edge.
REQ-004 Port srst, input, 1: reset, asynchronous and active-high.
REQ-005 Ports req0 and req1, input, 1 each: requester n has a word valid on dinn.
REQ-006 Ports din0 and din1, input, DW each: requester n write data.
REQ-007 Ports last0 and last1, input, 1 each: the current word is the final word of requester n's burst.
REQ-008 Ports gnt0 and gnt1, output, 1 each, registered: requester n owns the FIFO write port.
REQ-009 Ports ack0 and ack1, output, 1 each, combinational: the word on dinn is written this cycle.
REQ-010 Port fifo_wr_en, output, 1, combinational: write strobe to the shared 32-entry FIFO.
REQ-011 Port fifo_din, output, DW, combinational: write data to the FIFO.
REQ-012 Port fifo_full, input, 1: FIFO full flag, combinational from FIFO pointers.
REQ-013 Port busy, output, 1, registered: a grant is held.

Function
REQ-014 The FSM SHALL have states IDLE, OWN0 and OWN1; gnt0=1 only in OWN0, gnt1=1 only in OWN1, and busy=gnt0|gnt1.
REQ-015 In IDLE with any reqn=1, the FSM SHALL move to an OWN state next cycle per the policy in REQ-023/024; with no request it SHALL stay in IDLE.
REQ-016 In OWNn, ackn = reqn & ~fifo_full, ack of the non-owner = 0, fifo_wr_en = ackn, and fifo_din = dinn; in IDLE, fifo_wr_en=0 and fifo_din=0.
REQ-017 A requester SHALL hold reqn, dinn and lastn stable until acked; the block never writes when fifo_full=1 and never drops a word.
REQ-018 The burst counter SHALL reset to 0 on grant, increment on each ack, and be sized ceil(log2(BURST_MAX+1)) bits.
REQ-019 The grant SHALL be released at the end of the cycle in which any of these holds: an ack with lastn=1; an ack making the count equal BURST_MAX; reqn=0.
REQ-020 On release the next state SHALL be the other OWN state if the other requester asserts req, else OWNn again if reqn=1 (count restarts), else IDLE; there is no bubble cycle.
REQ-021 While fifo_full=1 the grant SHALL be held, and the count and FSM state SHALL not change.
REQ-022 If both requesters assert req in IDLE in the same cycle, exactly one grant SHALL issue; gnt0 and gnt1 are never both 1.

Configuration
REQ-023 With macro FIFO_WR_ARB_RR_EN defined, arbitration SHALL be round-robin: a 1-bit pointer names the last owner, and on contention the other port wins.
REQ-024 Without FIFO_WR_ARB_RR_EN, arbitration SHALL be fixed priority: port 0 wins every contention, including at release from OWN0 when req0 is still 1.

Reset
REQ-025 While srst=1 the FSM SHALL be in IDLE, with gnt0, gnt1, busy, ack0, ack1 and fifo_wr_en = 0, burst counter = 0, and round-robin pointer = 1, so port 0 wins first.
REQ-026 Reset asserted mid-burst SHALL abort immediately with no further write, and after srst falls the next grant SHALL follow REQ-015.

Verification
REQ-027 Reset, then req0=1 with last0 on word 3 and fifo_full=0 -> gnt0 rises 1 cycle later, 3 acks on consecutive cycles, then IDLE and gnt0=0.
REQ-028 req0 and req1 asserted continuously with BURST_MAX=8 and RR_EN defined -> grants alternate 8 words of port 0, 8 words of port 1, with no idle cycle between bursts.
REQ-029 Same stimulus without RR_EN -> port 0 is granted permanently and ack1 stays 0.
REQ-030 fifo_full=1 for 5 cycles mid-burst at count 4 -> fifo_wr_en=0 and the count holds at 4; after full drops, the remaining 4 words are written and fifo_din matches din0 order.
REQ-031 srst pulsed during OWN1 at count 2 -> gnt1=0 and fifo_wr_en=0 within the same cycle; after release with both requesting, port 0 is granted.

Source files
------------

// File: rtl/fifo_wr_arb.sv
// ----------------------------------------------------------------------------
// fifo_wr_arb
//   Arbitrates two burst-oriented requesters onto the single write port of a
//   shared 32-entry FIFO. The owner holds the port until it marks its last
//   word, reaches BURST_MAX words, or withdraws its request. On release the
//   next owner is chosen in the same cycle, so bursts follow each other
//   without a bubble.
//
//   Build option:
//     FIFO_WR_ARB_RR_EN  defined   -> round-robin on contention (a 1-bit
//                                     pointer remembers the last owner)
//                        undefined -> fixed priority, port 0 always wins
//
//   Parameters:
//     DW         data width of both requesters and of the FIFO write port
//     BURST_MAX  maximum words accepted per grant (1..32)
//
//   Ports:
//     clk              clock, all state on the rising edge
//     srst             asynchronous active-high reset
//     req0/req1        requester n presents a valid word on din n
//     din0/din1        requester write data
//     last0/last1      current word is the final word of the burst
//     gnt0/gnt1        registered: requester n owns the write port
//     ack0/ack1        combinational: the word on din n is written this cycle
//     fifo_wr_en       combinational FIFO write strobe
//     fifo_din         combinational FIFO write data (0 while idle)
//     fifo_full        FIFO full flag
//     busy             registered: some grant is held
// ----------------------------------------------------------------------------
module fifo_wr_arb #(
   parameter int DW        = 32,
   parameter int BURST_MAX = 8
) (
   input  logic          clk,
   input  logic          srst,
   input  logic          req0,
   input  logic          req1,
   input  logic [DW-1:0] din0,
   input  logic [DW-1:0] din1,
   input  logic          last0,
   input  logic          last1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          ack0,
   output logic          ack1,
   output logic          fifo_wr_en,
   output logic [DW-1:0] fifo_din,
   input  logic          fifo_full,
   output logic          busy
);

   localparam int            CW          = $clog2(BURST_MAX + 1);
   // Count value at which one more ack completes a maximal burst.
   localparam logic [CW-1:0] LP_CNT_LAST = CW'(BURST_MAX - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   state_t        w_pick;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic          r_gnt0;
   logic          r_gnt1;
   logic          r_busy;
   logic          w_own_req;
   logic          w_own_last;
   logic          w_own_ack;
   logic          w_arb;

`ifdef FIFO_WR_ARB_RR_EN
   // 1 = port 1 owned last. Resets to 1 so port 0 wins the first contention.
   logic          r_last_own;
`endif

   // Winner among the current requests, used whenever the port is free or
   // is being released this cycle.
   always_comb begin
      w_pick = ST_IDLE;
      if (req0 && req1) begin
`ifdef FIFO_WR_ARB_RR_EN
         w_pick = r_last_own ? ST_OWN0 : ST_OWN1;
`else
         w_pick = ST_OWN0;
`endif
      end else if (req0) begin
         w_pick = ST_OWN0;
      end else if (req1) begin
         w_pick = ST_OWN1;
      end
   end

   // Write-port mux, burst accounting and next-state decision.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case leaves a value unassigned and no latch is inferred.
      ack0        = 1'b0;
      ack1        = 1'b0;
      fifo_wr_en  = 1'b0;
      fifo_din    = '0;
      w_own_req   = 1'b0;
      w_own_last  = 1'b0;
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;

      case (r_state)
         ST_OWN0: begin
            ack0       = req0 & ~fifo_full;
            fifo_wr_en = ack0;
            fifo_din   = din0;
            w_own_req  = req0;
            w_own_last = last0;
         end
         ST_OWN1: begin
            ack1       = req1 & ~fifo_full;
            fifo_wr_en = ack1;
            fifo_din   = din1;
            w_own_req  = req1;
            w_own_last = last1;
         end
         default: ;
      endcase

      w_own_ack = ack0 | ack1;

      // Arbitrate when idle or when the owner lets go. A stalled owner
      // (req high, FIFO full) never arbitrates, so state and count hold.
      w_arb = (r_state == ST_IDLE) | ~w_own_req |
              (w_own_ack & (w_own_last | (r_cnt == LP_CNT_LAST)));

      if (w_arb) begin
         w_state_nxt = w_pick;
         w_cnt_nxt   = '0;
      end else if (w_own_ack) begin
         w_cnt_nxt   = r_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge srst) begin
      if (srst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_gnt0  <= 1'b0;
         r_gnt1  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments for all state, so every register
         // samples the pre-edge values regardless of statement order.
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_gnt0  <= (w_state_nxt == ST_OWN0);
         r_gnt1  <= (w_state_nxt == ST_OWN1);
         r_busy  <= (w_state_nxt != ST_IDLE);
      end
   end

`ifdef FIFO_WR_ARB_RR_EN
   always_ff @(posedge clk or posedge srst) begin
      if (srst) begin
         r_last_own <= 1'b1;
      end else if (w_arb && (w_pick != ST_IDLE)) begin
         r_last_own <= (w_pick == ST_OWN1);
      end
   end
`else
   // Fixed priority keeps no arbitration history.
`endif

   assign gnt0 = r_gnt0;
   assign gnt1 = r_gnt1;
   assign busy = r_busy;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// ----------------------------------------------------------------------------
// tb_fifo_wr_arb
//   Self-checking bench for fifo_wr_arb (DW=32, BURST_MAX=8). Each requester
//   is a queue of words; a reference model tracks the owner, the word count
//   of the current burst and the last owner as plain integers and predicts
//   grants, acks and FIFO write data every cycle. Honors FIFO_WR_ARB_RR_EN
//   the same way as the design.
// ----------------------------------------------------------------------------
module tb_fifo_wr_arb;

   localparam int DW   = 32;
   localparam int BMAX = 8;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } word_t;

   logic          clk = 1'b0;
   logic          srst = 1'b1;
   logic          req0 = 1'b0, req1 = 1'b0;
   logic [DW-1:0] din0 = '0, din1 = '0;
   logic          last0 = 1'b0, last1 = 1'b0;
   logic          fifo_full = 1'b0;
   logic          gnt0, gnt1, ack0, ack1, fifo_wr_en, busy;
   logic [DW-1:0] fifo_din;

   always #5 clk = ~clk;

   fifo_wr_arb #(.DW(DW), .BURST_MAX(BMAX)) dut (
      .clk        (clk),
      .srst       (srst),
      .req0       (req0),
      .req1       (req1),
      .din0       (din0),
      .din1       (din1),
      .last0      (last0),
      .last1      (last1),
      .gnt0       (gnt0),
      .gnt1       (gnt1),
      .ack0       (ack0),
      .ack1       (ack1),
      .fifo_wr_en (fifo_wr_en),
      .fifo_din   (fifo_din),
      .fifo_full  (fifo_full),
      .busy       (busy)
   );

   // Requester state: pending words and whether the head word is presented.
   word_t q0[$], q1[$];
   bit    pres0 = 0, pres1 = 0;

   // Reference model: owner -1 = nobody, count of words in the burst so far,
   // last owner for round-robin (1 after reset so port 0 wins first).
   int m_owner = -1;
   int m_cnt   = 0;
   int m_last  = 1;

   int n_checks = 0;
   int n_errors = 0;

   // Observed DUT activity (counted from DUT outputs, not from the model).
   int            dut_ack0 = 0, dut_ack1 = 0;
   logic [DW-1:0] wr_log[$];

   function automatic word_t mk(input logic [DW-1:0] d, input logic l);
      word_t w;
      w.data = d;
      w.last = l;
      return w;
   endfunction

   function automatic int pick(input logic r0, input logic r1);
      int win;
      win = -1;
      if (r0 && r1) begin
`ifdef FIFO_WR_ARB_RR_EN
         win = 1 - m_last;
`else
         win = 0;
`endif
      end else if (r0) begin
         win = 0;
      end else if (r1) begin
         win = 1;
      end
      return win;
   endfunction

   // One clock cycle: drive at the falling edge, compare 1 time unit later,
   // then advance the model to what the next rising edge should produce.
   task automatic run_cycle(input int rate, input int full_pct);
      logic [5:0]    exp_v, got_v;
      logic [DW-1:0] exp_din;
      bit            e_ack0, e_ack1, o_req, o_last, o_ack, arb;
      @(negedge clk);
      if (!pres0 && q0.size() > 0 && $urandom_range(99) < rate) pres0 = 1;
      if (!pres1 && q1.size() > 0 && $urandom_range(99) < rate) pres1 = 1;
      req0      = pres0;
      din0      = pres0 ? q0[0].data : DW'($urandom);
      last0     = pres0 ? q0[0].last : 1'($urandom_range(1));
      req1      = pres1;
      din1      = pres1 ? q1[0].data : DW'($urandom);
      last1     = pres1 ? q1[0].last : 1'($urandom_range(1));
      fifo_full = ($urandom_range(99) < full_pct);
      #1;
      e_ack0  = (m_owner == 0) && req0 && !fifo_full;
      e_ack1  = (m_owner == 1) && req1 && !fifo_full;
      exp_din = (m_owner == 0) ? din0 : (m_owner == 1) ? din1 : '0;
      exp_v   = {m_owner == 0, m_owner == 1, m_owner >= 0, e_ack0, e_ack1, e_ack0 | e_ack1};
      got_v   = {gnt0, gnt1, busy, ack0, ack1, fifo_wr_en};
      n_checks++;
      if (got_v !== exp_v) begin
         n_errors++;
         $display("FAIL ctrl t=%0t {gnt0,gnt1,busy,ack0,ack1,wr_en} got %b expected %b",
                  $time, got_v, exp_v);
      end
      n_checks++;
      if (fifo_din !== exp_din) begin
         n_errors++;
         $display("FAIL fifo_din t=%0t got %h expected %h", $time, fifo_din, exp_din);
      end
      if (ack0 === 1'b1) dut_ack0++;
      if (ack1 === 1'b1) dut_ack1++;
      if (fifo_wr_en === 1'b1) wr_log.push_back(fifo_din);

      if (srst) begin
         m_owner = -1;
         m_cnt   = 0;
         m_last  = 1;
      end else begin
         if (m_owner < 0) begin
            arb = 1;
         end else begin
            o_req  = (m_owner == 0) ? req0 : req1;
            o_last = (m_owner == 0) ? last0 : last1;
            o_ack  = e_ack0 | e_ack1;
            arb    = !o_req || (o_ack && (o_last || (m_cnt + 1 == BMAX)));
            if (!arb && o_ack) m_cnt++;
         end
         if (arb) begin
            m_owner = pick(req0, req1);
            m_cnt   = 0;
            if (m_owner >= 0) m_last = m_owner;
         end
      end
      if (e_ack0) begin void'(q0.pop_front()); pres0 = 0; end
      if (e_ack1) begin void'(q1.pop_front()); pres1 = 0; end
   endtask

   // Let all pending words go out, then confirm the port is released.
   task automatic drain(input string tag);
      int cyc;
      cyc = 0;
      while ((q0.size() + q1.size() > 0 || m_owner >= 0) && cyc < 400) begin
         run_cycle(100, 0);
         cyc++;
      end
      run_cycle(100, 0);
      n_checks++;
      if (busy !== 1'b0) begin
         n_errors++;
         $display("FAIL %s_idle busy got %b expected 0", tag, busy);
      end
   endtask

   task automatic test_reset();
      q0.push_back(mk(32'hA0A0_0001, 1'b1));
      q1.push_back(mk(32'hB0B0_0001, 1'b1));
      repeat (3) run_cycle(100, 0);
      n_checks++;
      if ({gnt0, gnt1, busy, ack0, ack1, fifo_wr_en} !== 6'b0 || fifo_din !== '0) begin
         n_errors++;
         $display("FAIL reset_outputs got %b din %h expected 000000 din 0",
                  {gnt0, gnt1, busy, ack0, ack1, fifo_wr_en}, fifo_din);
      end
      @(posedge clk);
      #1 srst = 1'b0;
      // Both request right after reset: port 0 must be the first owner.
      run_cycle(100, 0);
      run_cycle(100, 0);
      n_checks++;
      if ({gnt0, gnt1} !== 2'b10) begin
         n_errors++;
         $display("FAIL reset_first_grant {gnt0,gnt1} got %b expected 10", {gnt0, gnt1});
      end
      drain("reset");
   endtask

   task automatic test_single_burst();
      word_t sent[3];
      int    base_wr, base_ack;
      for (int i = 0; i < 3; i++) begin
         sent[i] = mk(32'h1000_0000 + DW'(i), (i == 2));
         q0.push_back(sent[i]);
      end
      base_wr  = wr_log.size();
      base_ack = dut_ack0;
      run_cycle(100, 0);
      n_checks++;
      if (gnt0 !== 1'b0) begin
         n_errors++;
         $display("FAIL single_gnt_latency gnt0 got %b expected 0 in request cycle", gnt0);
      end
      run_cycle(100, 0);
      n_checks++;
      if ({gnt0, ack0} !== 2'b11) begin
         n_errors++;
         $display("FAIL single_first_ack {gnt0,ack0} got %b expected 11", {gnt0, ack0});
      end
      drain("single");
      n_checks++;
      if (dut_ack0 - base_ack !== 3 || wr_log.size() - base_wr !== 3) begin
         n_errors++;
         $display("FAIL single_count acks got %0d writes got %0d expected 3",
                  dut_ack0 - base_ack, wr_log.size() - base_wr);
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (wr_log[base_wr + i] !== sent[i].data) begin
               n_errors++;
               $display("FAIL single_data[%0d] got %h expected %h", i,
                        wr_log[base_wr + i], sent[i].data);
            end
         end
      end
   endtask

   task automatic test_contention();
      int a0, a1;
      for (int i = 0; i < 48; i++) begin
         q0.push_back(mk(32'h2000_0000 + DW'(i), 1'b0));
         q1.push_back(mk(32'h3000_0000 + DW'(i), 1'b0));
      end
      a0 = dut_ack0;
      a1 = dut_ack1;
      repeat (48) run_cycle(100, 0);
      a0 = dut_ack0 - a0;
      a1 = dut_ack1 - a1;
      // One arbitration cycle, then a write on every one of the 47 cycles.
      n_checks++;
      if (a0 + a1 !== 47) begin
         n_errors++;
         $display("FAIL contention_no_bubble writes got %0d expected 47", a0 + a1);
      end
`ifdef FIFO_WR_ARB_RR_EN
      n_checks++;
      if (a0 < 23 || a0 > 24 || a1 < 23 || a1 > 24) begin
         n_errors++;
         $display("FAIL contention_rr_share ack0 %0d ack1 %0d expected 24/23 split", a0, a1);
      end
`else
      n_checks++;
      if (a1 !== 0 || a0 !== 47) begin
         n_errors++;
         $display("FAIL contention_fixed ack0 got %0d ack1 got %0d expected 47 and 0", a0, a1);
      end
`endif
      drain("contention");
   endtask

   task automatic test_full_stall();
      word_t sent[8];
      int    cyc, base_wr, stall_wr;
      for (int i = 0; i < 8; i++) begin
         sent[i] = mk(32'h4000_0000 + DW'(i), 1'b0);
         q0.push_back(sent[i]);
      end
      base_wr = wr_log.size();
      cyc = 0;
      while (!(m_owner == 0 && m_cnt == 4) && cyc < 20) begin
         run_cycle(100, 0);
         cyc++;
      end
      n_checks++;
      if (cyc >= 20) begin
         n_errors++;
         $display("FAIL full_setup model did not reach count 4 within %0d cycles", cyc);
      end
      stall_wr = wr_log.size();
      for (int i = 0; i < 5; i++) begin
         run_cycle(100, 100);
         n_checks++;
         if (dut.r_cnt !== 4 || gnt0 !== 1'b1) begin
            n_errors++;
            $display("FAIL full_hold cycle %0d count got %0d gnt0 %b expected 4 and 1",
                     i, dut.r_cnt, gnt0);
         end
      end
      n_checks++;
      if (wr_log.size() !== stall_wr) begin
         n_errors++;
         $display("FAIL full_no_write writes during full got %0d expected 0",
                  wr_log.size() - stall_wr);
      end
      drain("full");
      n_checks++;
      if (wr_log.size() - base_wr !== 8) begin
         n_errors++;
         $display("FAIL full_total writes got %0d expected 8", wr_log.size() - base_wr);
      end else begin
         for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (wr_log[base_wr + i] !== sent[i].data) begin
               n_errors++;
               $display("FAIL full_order[%0d] got %h expected %h", i,
                        wr_log[base_wr + i], sent[i].data);
            end
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      int cyc;
      for (int i = 0; i < 6; i++) q1.push_back(mk(32'h5000_0000 + DW'(i), 1'b0));
      cyc = 0;
      while (!(m_owner == 1 && m_cnt == 2) && cyc < 20) begin
         run_cycle(100, 0);
         cyc++;
      end
      @(posedge clk);
      // Present the third word, confirm it would be written, then reset.
      @(negedge clk);
      pres1 = 1;
      req1  = 1'b1;
      din1  = q1[0].data;
      last1 = q1[0].last;
      fifo_full = 1'b0;
      #1;
      n_checks++;
      if ({gnt1, ack1, fifo_wr_en} !== 3'b111) begin
         n_errors++;
         $display("FAIL midrst_pre {gnt1,ack1,wr_en} got %b expected 111", {gnt1, ack1, fifo_wr_en});
      end
      srst = 1'b1;
      #1;
      n_checks++;
      if ({gnt1, busy, ack1, fifo_wr_en} !== 4'b0) begin
         n_errors++;
         $display("FAIL midrst_abort {gnt1,busy,ack1,wr_en} got %b expected 0000",
                  {gnt1, busy, ack1, fifo_wr_en});
      end
      m_owner = -1;
      m_cnt   = 0;
      m_last  = 1;
      for (int i = 0; i < 4; i++) q0.push_back(mk(32'h6000_0000 + DW'(i), 1'b0));
      repeat (2) run_cycle(100, 0);
      @(posedge clk);
      #1 srst = 1'b0;
      cyc = 0;
      while (busy !== 1'b1 && cyc < 5) begin
         run_cycle(100, 0);
         cyc++;
      end
      n_checks++;
      if ({gnt0, gnt1} !== 2'b10) begin
         n_errors++;
         $display("FAIL midrst_regrant {gnt0,gnt1} got %b expected 10", {gnt0, gnt1});
      end
      drain("midrst");
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         if (q0.size() < 4) q0.push_back(mk(DW'($urandom), ($urandom_range(3) == 0)));
         if (q1.size() < 4) q1.push_back(mk(DW'($urandom), ($urandom_range(3) == 0)));
         run_cycle(60, 20);
      end
      drain("random");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_burst();
      test_contention();
      test_full_stall();
      test_reset_mid_burst();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
